// File: rtl/fifo_burst_drain_ctrl.sv
// fifo_burst_drain_ctrl
// Read-side scheduler for a synchronous FIFO. It tracks occupancy from the
// write/read handshakes and starts a burst once BURST_LEN words are waiting,
// or once a partial load has sat idle for TIMEOUT cycles. Drained words go
// out on a valid/ready stream with sop/eop markers. A 2-entry output buffer
// absorbs the FIFO's one-cycle read latency.
module fifo_burst_drain_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 8,
    parameter int TMR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush_req,
    input  logic                  fifo_write_ack,
    input  logic                  fifo_empty,
    input  logic                  fifo_rdata_valid,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  fifo_read_req,
    output logic                  fifo_flush,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_sop,
    output logic                  m_eop,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  busy
);

    localparam int LVL_W = ADDR_WIDTH + 1;
    localparam logic [LVL_W-1:0]     DEPTH_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]     BURST_LVL = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0]     LVL_ONE   = LVL_W'(1);
    localparam logic [TMR_WIDTH-1:0] TMR_LAST  = TMR_WIDTH'(TIMEOUT - 1);
    localparam logic [TMR_WIDTH-1:0] TMR_ONE   = TMR_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [TMR_WIDTH-1:0]   timer_q, timer_d;
    logic [LVL_W-1:0]       remaining_q, remaining_d;
    logic                   first_q, first_d;
    logic                   inflight_q, inflight_d;
    logic                   tag_sop_q, tag_sop_d;
    logic                   tag_eop_q, tag_eop_d;

    // Output buffer: two slots plus pointers and a fill count
    logic [DATA_WIDTH-1:0]  obuf_data_q [2];
    logic                   obuf_sop_q  [2];
    logic                   obuf_eop_q  [2];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             count_q, count_d;

    logic                   obuf_valid;
    logic                   pop;
    logic                   push;
    logic                   read_req;
    logic [2:0]             occ;
    logic                   drain_done;

    assign obuf_valid = (count_q != 2'd0);
    assign pop        = obuf_valid && m_ready;
    // Read data is only accepted against an outstanding request; a flush
    // discards whatever returns in the same cycle.
    assign push       = fifo_rdata_valid && inflight_q && !flush_req;

    // Words already committed to the buffer (stored or in flight), less the
    // one leaving this cycle. Keeping this below 2 means the buffer never overflows.
    assign occ = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign read_req = (state_q == ST_BURST) && (remaining_q != '0) && !fifo_empty
                      && !flush_req && (occ < 3'd2);

    // DRAIN ends once nothing is in flight and the buffer empties this cycle.
    assign drain_done = !inflight_q &&
                        ((count_q == 2'd0) || ((count_q == 2'd1) && pop));

    assign fifo_read_req = read_req;
    assign fifo_flush    = flush_req && reset_n;
    assign m_valid       = obuf_valid;
    assign m_data        = obuf_valid ? obuf_data_q[rd_ptr_q] : '0;
    assign m_sop         = obuf_valid ? obuf_sop_q[rd_ptr_q]  : 1'b0;
    assign m_eop         = obuf_valid ? obuf_eop_q[rd_ptr_q]  : 1'b0;
    assign level         = level_q;
    assign busy          = (state_q != ST_IDLE);

    // Next-state logic: timer/threshold in IDLE, issue counting in BURST, wait-out in DRAIN
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        case (state_q)
            ST_IDLE: begin
                if (level_q == '0) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
                if ((level_q >= BURST_LVL) ||
                    ((level_q != '0) && (timer_q == TMR_LAST))) begin
                    state_d     = ST_BURST;
                    timer_d     = '0;
                    remaining_d = (level_q >= BURST_LVL) ? BURST_LVL : level_q;
                    first_d     = 1'b1;
                end
            end
            ST_BURST: begin
                timer_d = '0;
                if (read_req) begin
                    remaining_d = remaining_q - LVL_ONE;
                    first_d     = 1'b0;
                    if (remaining_q == LVL_ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                timer_d = '0;
                if (drain_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
        if (flush_req) begin
            state_d     = ST_IDLE;
            timer_d     = '0;
            remaining_d = '0;
            first_d     = 1'b0;
        end
    end

    // Occupancy: +1 write, -1 read, hold when both, saturate at DEPTH and 0
    always_comb begin
        level_d = level_q;
        if (flush_req) begin
            level_d = '0;
        end else if (fifo_write_ack && !read_req) begin
            if (level_q != DEPTH_LVL) begin
                level_d = level_q + LVL_ONE;
            end
        end else if (!fifo_write_ack && read_req) begin
            if (level_q != '0) begin
                level_d = level_q - LVL_ONE;
            end
        end
    end

    // In-flight request tracking; the sop/eop tag is fixed when the read issues
    always_comb begin
        inflight_d = inflight_q;
        tag_sop_d  = tag_sop_q;
        tag_eop_d  = tag_eop_q;
        if (fifo_rdata_valid) begin
            inflight_d = 1'b0;
        end
        if (read_req) begin
            inflight_d = 1'b1;
            tag_sop_d  = first_q;
            tag_eop_d  = (remaining_q == LVL_ONE);
        end
        if (flush_req) begin
            inflight_d = 1'b0;
            tag_sop_d  = 1'b0;
            tag_eop_d  = 1'b0;
        end
    end

    // Output buffer pointer and count update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (flush_req) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            timer_q     <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            inflight_q  <= 1'b0;
            tag_sop_q   <= 1'b0;
            tag_eop_q   <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            inflight_q  <= inflight_d;
            tag_sop_q   <= tag_sop_d;
            tag_eop_q   <= tag_eop_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Buffer slot storage; contents are masked at the outputs while empty, so no reset
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_obuf_slot
            always_ff @(posedge clk) begin
                if (push && (int'(wr_ptr_q) == gi)) begin
                    obuf_data_q[gi] <= fifo_read_data;
                    obuf_sop_q[gi]  <= tag_sop_q;
                    obuf_eop_q[gi]  <= tag_eop_q;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_burst_drain_ctrl.sv
// Directed bench for fifo_burst_drain_ctrl: a small FIFO model feeds the
// DUT, a per-cycle vector table covers the basic burst, and hand-written
// sequences cover timeout, backpressure, overlap, flush and async reset.
module tb_fifo_burst_drain_ctrl;

    localparam int DW = 16;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush_req;
    logic          fifo_write_ack;
    logic          fifo_empty;
    logic          fifo_rdata_valid;
    logic [DW-1:0] fifo_read_data;
    logic          fifo_read_req;
    logic          fifo_flush;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_sop;
    logic          m_eop;
    logic          m_ready;
    logic [LW-1:0] level;
    logic          busy;
    logic [DW-1:0] wr_data;

    fifo_burst_drain_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .flush_req        (flush_req),
        .fifo_write_ack   (fifo_write_ack),
        .fifo_empty       (fifo_empty),
        .fifo_rdata_valid (fifo_rdata_valid),
        .fifo_read_data   (fifo_read_data),
        .fifo_read_req    (fifo_read_req),
        .fifo_flush       (fifo_flush),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_sop            (m_sop),
        .m_eop            (m_eop),
        .m_ready          (m_ready),
        .level            (level),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Behavioral FIFO: read data valid one cycle after the request
    logic [DW-1:0] fmem [16];
    logic [3:0]    fwr, frd;
    logic [4:0]    fcnt;
    assign fifo_empty = (fcnt == 5'd0);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwr <= 4'd0; frd <= 4'd0; fcnt <= 5'd0;
            fifo_rdata_valid <= 1'b0; fifo_read_data <= '0;
        end else if (fifo_flush) begin
            fwr <= 4'd0; frd <= 4'd0; fcnt <= 5'd0;
            fifo_rdata_valid <= 1'b0;
        end else begin
            if (fifo_write_ack) begin
                fmem[fwr] <= wr_data;
                fwr <= fwr + 4'd1;
            end
            if (fifo_read_req) begin
                fifo_read_data <= fmem[frd];
                frd <= frd + 4'd1;
            end
            fifo_rdata_valid <= fifo_read_req;
            fcnt <= fcnt + {4'd0, fifo_write_ack} - {4'd0, fifo_read_req};
        end
    end

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } word_t;

    typedef struct packed {
        logic          wr;
        logic [DW-1:0] wd;
        logic          rdy;
        logic          fl;
        logic          req;
        logic          mv;
        logic [DW-1:0] md;
        logic          sop;
        logic          eop;
        logic [LW-1:0] lvl;
        logic          busy;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    word_t  got[$];
    int     outstanding;
    logic   prev_stall;
    word_t  prev_w;
    vec_t   vecs [12];

    function automatic vec_t mkv(input logic wr, input logic [DW-1:0] wd, input logic req,
                                 input logic mv, input logic [DW-1:0] md, input logic sop,
                                 input logic eop, input logic [LW-1:0] lvl, input logic bsy);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rdy = 1'b1; v.fl = 1'b0;
        v.req = req; v.mv = mv; v.md = md; v.sop = sop; v.eop = eop;
        v.lvl = lvl; v.busy = bsy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle sampling: stall stability, buffer-occupancy bound, pop capture
    task automatic monitor();
        logic p;
        if (!reset_n) begin
            outstanding = 0;
            prev_stall  = 1'b0;
            return;
        end
        p = m_valid && m_ready;
        if (prev_stall)
            chk("stall_hold", 64'({m_valid, m_data, m_sop, m_eop}), 64'({1'b1, prev_w}));
        if (fifo_read_req)
            chk("bp_limit", 64'((outstanding - int'(p)) < 2), 64'd1);
        if (p) begin
            got.push_back({m_data, m_sop, m_eop});
            $display("t=%0t word data=0x%04h sop=%0b eop=%0b", $time, m_data, m_sop, m_eop);
        end
        if (fifo_flush) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            outstanding = outstanding + int'(fifo_read_req) - int'(p);
            prev_stall  = m_valid && !m_ready;
            prev_w      = {m_data, m_sop, m_eop};
        end
    endtask

    task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        fifo_write_ack = wr;
        wr_data        = d;
        m_ready        = rdy;
        flush_req      = fl;
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        int k = 0;
        while (got.size() < n && k < budget) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            k++;
        end
        chk({name, "_count"}, 64'(got.size()), 64'(n));
    endtask

    task automatic chk_word(input string name, input int idx, input logic [DW-1:0] d,
                            input logic s, input logic e);
        if (idx < got.size()) begin
            chk(name, 64'(got[idx]), 64'({d, s, e}));
        end else begin
            checks++;
            errors++;
            $display("FAIL %s missing word %0d required=0x%0h", name, idx, {d, s, e});
        end
    endtask

    task automatic check_burst(input int off, input logic [DW-1:0] base, input int n,
                               input string name);
        for (int i = 0; i < n; i++)
            chk_word($sformatf("%s%0d", name, off + i), off + i, base + DW'(i),
                     i == 0, i == n - 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; flush_req = 1'b0; fifo_write_ack = 1'b0; wr_data = '0;
        m_ready = 1'b0; outstanding = 0; prev_stall = 1'b0; prev_w = '0;

        // Test 1 table: wr, wdata | req, m_valid, m_data, sop, eop, level, busy
        vecs[0]  = mkv(1, 16'h0001, 0, 0, 16'h0000, 0, 0, 5'd0, 0);
        vecs[1]  = mkv(1, 16'h0002, 0, 0, 16'h0000, 0, 0, 5'd1, 0);
        vecs[2]  = mkv(1, 16'h0003, 0, 0, 16'h0000, 0, 0, 5'd2, 0);
        vecs[3]  = mkv(1, 16'h0004, 0, 0, 16'h0000, 0, 0, 5'd3, 0);
        vecs[4]  = mkv(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5'd4, 0);
        vecs[5]  = mkv(0, 16'h0000, 1, 0, 16'h0000, 0, 0, 5'd4, 1);
        vecs[6]  = mkv(0, 16'h0000, 1, 0, 16'h0000, 0, 0, 5'd3, 1);
        vecs[7]  = mkv(0, 16'h0000, 1, 1, 16'h0001, 1, 0, 5'd2, 1);
        vecs[8]  = mkv(0, 16'h0000, 1, 1, 16'h0002, 0, 0, 5'd1, 1);
        vecs[9]  = mkv(0, 16'h0000, 0, 1, 16'h0003, 0, 0, 5'd0, 1);
        vecs[10] = mkv(0, 16'h0000, 0, 1, 16'h0004, 0, 1, 5'd0, 1);
        vecs[11] = mkv(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5'd0, 0);

        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("reset_outputs", 64'({fifo_read_req, fifo_flush, m_data, m_valid, m_sop, m_eop,
                                  level, busy}), 64'd0);
        reset_n = 1'b1;
        cycle(0, '0, 1, 0);
        cycle(0, '0, 1, 0);
        got.delete();

        // 1: basic 4-word burst, cycle by cycle
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].wr, vecs[i].wd, vecs[i].rdy, vecs[i].fl);
            chk($sformatf("t1_row%0d", i),
                64'({fifo_read_req, m_valid, m_data, m_sop, m_eop, level, busy}),
                64'({vecs[i].req, vecs[i].mv, vecs[i].md, vecs[i].sop, vecs[i].eop,
                     vecs[i].lvl, vecs[i].busy}));
        end
        check_burst(0, 16'h0001, 4, "t1_word");
        got.delete();

        // 2: partial load forced out by the timeout
        cycle(1, 16'h0021, 1, 0);
        cycle(1, 16'h0022, 1, 0);
        for (int k = 2; k <= 8; k++) cycle(0, '0, 1, 0);
        chk("t2_busy_before_timeout", 64'(busy), 64'd0);
        cycle(0, '0, 1, 0);
        chk("t2_burst_start", 64'({busy, fifo_read_req}), 64'b11);
        wait_words(2, 20, "t2");
        check_burst(0, 16'h0021, 2, "t2_word");
        got.delete();
        for (int k = 0; k < 3; k++) cycle(0, '0, 1, 0);
        chk("t2_idle", 64'({busy, m_valid, level}), 64'd0);

        // 3: 4-word burst with m_ready toggling
        for (int k = 0; k < 30; k++)
            cycle(k < 4, DW'(16'h0031 + k), (k % 2) == 0, 0);
        wait_words(4, 20, "t3");
        check_burst(0, 16'h0031, 4, "t3_word");
        got.delete();
        chk("t3_idle", 64'({busy, m_valid, level}), 64'd0);

        // 4: 8 words written back-to-back, overlapping the first burst
        for (int k = 0; k < 8; k++) begin
            cycle(1, DW'(16'h0041 + k), 1, 0);
            if (k >= 5)
                chk($sformatf("t4_coincide%0d", k), 64'({fifo_read_req, level}),
                    64'({1'b1, 5'd5}));
        end
        wait_words(8, 40, "t4");
        check_burst(0, 16'h0041, 4, "t4_word");
        check_burst(4, 16'h0045, 4, "t4_word");
        got.delete();
        for (int k = 0; k < 3; k++) cycle(0, '0, 1, 0);
        chk("t4_idle", 64'({busy, m_valid, level}), 64'd0);

        // 5: flush after two words delivered, with two more words still queued
        for (int k = 0; k < 9; k++) cycle(k < 6, DW'(16'h0051 + k), 1, 0);
        cycle(0, '0, 0, 1);
        chk("t5_flush_cycle", 64'({fifo_flush, fifo_read_req, level}), 64'({1'b1, 1'b0, 5'd2}));
        cycle(0, '0, 1, 0);
        chk("t5_after_flush", 64'({level, m_valid, busy, fifo_flush}), 64'd0);
        for (int k = 0; k < 12; k++) cycle(0, '0, 1, 0);
        chk("t5_delivered", 64'(got.size()), 64'd2);
        chk_word("t5_word0", 0, 16'h0051, 1, 0);
        chk_word("t5_word1", 1, 16'h0052, 0, 0);
        chk("t5_no_timeout_burst", 64'({busy, level}), 64'd0);
        got.delete();
        for (int k = 0; k < 4; k++) cycle(1, DW'(16'h0061 + k), 1, 0);
        wait_words(4, 30, "t5_next");
        check_burst(0, 16'h0061, 4, "t5_next_word");
        got.delete();
        for (int k = 0; k < 3; k++) cycle(0, '0, 1, 0);

        // 6: asynchronous reset mid-burst
        for (int k = 0; k < 8; k++) cycle(k < 4, DW'(16'h0071 + k), 1, 0);
        chk("t6_mid_burst", 64'({busy, m_valid}), 64'b11);
        reset_n = 1'b0;
        #1;
        chk("t6_async_reset", 64'({fifo_read_req, fifo_flush, m_data, m_valid, m_sop, m_eop,
                                   level, busy}), 64'd0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        reset_n = 1'b1;
        got.delete();
        outstanding = 0;
        prev_stall  = 1'b0;
        for (int k = 0; k < 4; k++) cycle(1, DW'(16'h0081 + k), 1, 0);
        wait_words(4, 30, "t6");
        check_burst(0, 16'h0081, 4, "t6_word");
        got.delete();
        for (int k = 0; k < 3; k++) cycle(0, '0, 1, 0);
        chk("t6_idle", 64'({busy, m_valid, level}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_burst_drain_ctrl.md
# fifo_burst_drain_ctrl

Read-side scheduler for the team's synchronous FIFO. It tracks FIFO occupancy from the write/read handshakes and decides when to drain. It starts a burst when enough words have accumulated, or when a timeout expires with a partial load. The drained words go to a valid/ready stream with start/end-of-burst markers, through a 2-entry output buffer that absorbs the FIFO's one-cycle read latency.

## Interface
- ADDR_WIDTH, 4, FIFO address width; occupancy width is ADDR_WIDTH+1
- DATA_WIDTH, 16, word width
- DEPTH, 16, FIFO depth in words
- BURST_LEN, 4, maximum words per burst (1..DEPTH)
- TIMEOUT, 8, idle cycles with a partial load before a short burst is forced (>=1)
- TMR_WIDTH, 8, timeout counter width
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush_req  in  1  abort everything and empty the FIFO
- fifo_write_ack  in  1  the FIFO accepted one word this cycle
- fifo_empty  in  1  FIFO empty flag
- fifo_rdata_valid  in  1  FIFO read data valid (one cycle after fifo_read_req)
- fifo_read_data  in  DATA_WIDTH  FIFO read data
- fifo_read_req  out  1  pop one word
- fifo_flush  out  1  FIFO flush
- m_data  out  DATA_WIDTH  output word
- m_valid  out  1  output word valid
- m_sop  out  1  first word of burst
- m_eop  out  1  last word of burst
- m_ready  in  1  sink accepts the word
- level  out  ADDR_WIDTH+1  tracked FIFO occupancy
- busy  out  1  state != IDLE

## Operation
- **Occupancy tracking (`level`)**
  - +1 on fifo_write_ack alone; -1 on fifo_read_req alone; unchanged when both occur in the same cycle.
  - Saturates at DEPTH and at 0.
- **Output buffer**
  - 2-entry FIFO of {data, sop, eop}.
  - A pop is m_valid && m_ready.
  - m_data, m_sop and m_eop are held stable while m_valid && !m_ready.
- **In-flight counter (`inflight`, 0..1)**
  - Set by fifo_read_req; cleared by fifo_rdata_valid.
  - The sop/eop tag is computed at issue and travels with the request.
  - A fifo_rdata_valid arriving with inflight==0 is ignored.
- **State machine: IDLE / BURST / DRAIN**
  - IDLE
    - The timer increments while level>0.
    - The timer clears while level==0 and on every exit from IDLE.
    - Go to BURST when level>=BURST_LEN, or when level>0 && timer==TIMEOUT-1.
    - On entry to BURST, load remaining = min(BURST_LEN, level).
  - BURST
    - fifo_read_req = remaining>0 && !fifo_empty && !flush_req && (obuf_count + inflight - pop) < 2.
    - Each request decrements remaining.
    - The first request of the burst carries sop; the request taking remaining to 0 carries eop.
    - On the request that takes remaining to 0, go to DRAIN.
    - A 1-word burst carries both sop and eop.
  - DRAIN
    - Go to IDLE when inflight==0, obuf_count==0 and no rdata is pending.
    - This is reached on the cycle after the eop word is popped.
- **Flush**
  - fifo_flush = flush_req, combinational, so the FIFO flushes on the same edge.
  - On that edge the block clears:
    - level, timer, remaining, inflight and the output buffer;
    - the state goes to IDLE.
  - fifo_write_ack in the flush cycle is discarded.
  - A mid-burst flush drops the remaining words; no m_eop is ever delivered for that burst.
- **Burst boundaries**
  - Words written during a burst are not added to it; they count toward the next burst.

## Timing
- **Reset values:** all outputs 0; state IDLE; level=0; timer=0; buffer empty.
  - Assertion of reset_n=0 forces these values immediately, independent of clk.
  - fifo_read_req and fifo_flush also reach 0 immediately: they are combinational, gated by state and flush_req.
- **Burst start:** the threshold is met at cycle N (registered level); the state is BURST at N+1; the first fifo_read_req is at N+1.
- **Read path:** fifo_read_req at cycle K → fifo_rdata_valid at K+1 → m_valid at K+2.
- **Throughput:** with m_ready held at 1, one word per cycle; a BURST_LEN burst occupies BURST_LEN consecutive m_valid cycles.
- **Combinational paths:** m_ready → fifo_read_req (through pop); flush_req → fifo_flush and fifo_read_req.
- **Backpressure:** fifo_read_req is never issued when (obuf_count + inflight - pop) >= 2, so the buffer never overflows.
- **busy** rises the cycle the state enters BURST and falls the cycle after the final pop.

## Test plan
1. Write 0x0001..0x0004 in 4 cycles with m_ready=1.
   - fifo_read_req on 4 consecutive cycles; m_data 1,2,3,4 back-to-back.
   - m_sop on 1, m_eop on 4; level returns to 0; busy drops one cycle after the eop pop.
2. Write 2 words, then stop.
   - Burst starts when the timer reaches TIMEOUT-1 (level>0 for 8 cycles).
   - Output is 2 words: sop on the first, eop on the second.
3. 4-word burst with m_ready toggling 1,0,1,0.
   - No loss or duplication; data is stable while stalled.
   - fifo_read_req is never asserted with buffer+inflight-pop>=2.
4. 8 words written on consecutive cycles while bursting.
   - Two bursts of 4 (sop/eop on words 1,4,5,8).
   - level unchanged in cycles where write_ack and read_req coincide.
5. flush_req after 2 of 4 words are delivered.
   - fifo_flush in the same cycle; level=0, m_valid=0 and IDLE next cycle.
   - No m_eop; a later 4-word write produces a clean sop-to-eop burst.
6. Assert reset_n=0 mid-burst.
   - All outputs go to 0 asynchronously; after release, a 4-word write bursts normally.
